// File: rtl/bsg_acm_output_frame_serializer.sv
// Captures one board per handshake and streams it as word-wide beats, with an
// optional header beat carrying the data beat count and a 16-bit frame id.
module bsg_acm_output_frame_serializer #(
  parameter int unsigned board_width_p    = 8,
  parameter int unsigned word_width_p     = 64,
  parameter bit          header_p         = 1'b1,
  parameter logic [15:0] frame_id_reset_p = 16'h0000
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [board_width_p*board_width_p-1:0] data_i,
  input  logic                                   v_i,
  output logic                                   yumi_o,
  output logic [word_width_p-1:0]                data_o,
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic                                   last_o
);

  localparam int unsigned cells_lp      = board_width_p * board_width_p;
  localparam int unsigned data_words_lp = (cells_lp + word_width_p - 1) / word_width_p;
  localparam int unsigned cnt_w_lp      = (data_words_lp > 1) ? $clog2(data_words_lp) : 1;
  localparam int unsigned pad_w_lp      = data_words_lp * word_width_p;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(data_words_lp - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e              state_q, state_d;
  logic [cells_lp-1:0] shadow_q, shadow_d;
  logic [cnt_w_lp-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]         frame_id_q, frame_id_d;

  logic [pad_w_lp-1:0] shadow_pad;
  logic [31:0]         hdr_word;
  logic                accept;
  logic                is_last;

  // Zero-extend so the final beat can be sliced without going out of range.
  assign shadow_pad = pad_w_lp'(shadow_q);
  assign hdr_word   = {16'(data_words_lp), frame_id_q};

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    beat_cnt_d = beat_cnt_q;
    frame_id_d = frame_id_q;
    v_o        = 1'b0;
    data_o     = '0;
    is_last    = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: accept = v_i;
      StHdr: begin
        v_o    = 1'b1;
        data_o = word_width_p'(hdr_word);
        if (yumi_i) state_d = StData;
      end
      StData: begin
        v_o     = 1'b1;
        data_o  = shadow_pad[beat_cnt_q*word_width_p +: word_width_p];
        is_last = (beat_cnt_q == last_cnt_lp);
        if (yumi_i) begin
          if (!is_last) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            frame_id_d = frame_id_q + 16'd1;
            beat_cnt_d = '0;
            accept     = v_i;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new board is only taken when idle or as the last beat leaves.
    if (accept) begin
      shadow_d   = data_i;
      beat_cnt_d = '0;
      state_d    = header_p ? StHdr : StData;
    end

    last_o = is_last;
    yumi_o = accept & ~reset_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      beat_cnt_q <= '0;
      frame_id_q <= frame_id_reset_p;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      beat_cnt_q <= beat_cnt_d;
      frame_id_q <= frame_id_d;
    end
  end

  yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
